sipo_rx_amisha: RTL and testbench
=================================

# sipo_rx_amisha

Serial-in, parallel-out frame receiver: the receive end of the shift-register serial link. It collects `N_amisha` serial bits, qualified by a valid strobe, into a word, either MSB-first or LSB-first. It then presents the word on a held parallel output with a valid/ready handshake. It sits between a serial line and a parallel consumer, and is the counterpart of the universal shift register driven as a transmitter.

## Interface
- `N_amisha`, default 8: word width in bits; must be ≥ 2.
- `clk_amisha`  in  1  clock; all state changes on the rising edge.
- `reset_amisha`  in  1  synchronous, active-high reset.
- `start_amisha`  in  1  one-cycle pulse that begins a frame; also latches `dir_amisha`.
- `dir_amisha`  in  1  bit order, sampled only with start.
  - 0: MSB-first; the shift-register update is {r[N-2:0], sin}.
  - 1: LSB-first; the shift-register update is {sin, r[N-1:1]}.
- `sin_amisha`  in  1  serial data bit.
- `sin_valid_amisha`  in  1  qualifies `sin_amisha` for the current cycle.
- `ready_amisha`  in  1  consumer accepts the held word.
- `q_amisha`  out  N  received word; holds its value until the next completed frame.
- `q_valid_amisha`  out  1  `q_amisha` holds an unconsumed word.
- `busy_amisha`  out  1  frame in progress (state SHIFT).
- `overrun_amisha`  out  1  sticky flag: a valid bit arrived while a word was pending.

## Operation
- Internal state:
  - shift register `sr` (N bits)
  - bit counter `cnt`, counting 0..N-1 (width $clog2(N))
  - latched direction bit
  - output register `q`
  - FSM with states IDLE, SHIFT, HOLD
- Reset (synchronous, dominates all other inputs, including mid-frame): state IDLE; `sr`, `cnt`, `q` = 0; `q_valid_amisha`, `busy_amisha`, `overrun_amisha` = 0; direction = 0.
- IDLE:
  - `sin_valid_amisha` is ignored.
  - On `start_amisha`: clear `sr` and `cnt`, latch the direction, clear overrun, go to SHIFT.
- SHIFT:
  - Each cycle with `sin_valid_amisha`=1: shift `sin_amisha` in per the latched direction and increment `cnt`.
  - Cycles with valid=0 leave `sr` and `cnt` unchanged (gaps are allowed).
  - On the valid bit with `cnt`=N-1:
    - load `q` with the fully shifted value (including this bit)
    - set `q_valid_amisha`
    - go to HOLD
  - `start_amisha` in SHIFT aborts the frame:
    - clear `sr` and `cnt`, re-latch the direction, stay in SHIFT
    - any `sin_valid_amisha` in the same cycle is discarded
    - `q` is untouched
- HOLD:
  - `q_amisha` is stable and `q_valid_amisha`=1.
  - `sin_valid_amisha`=1 sets `overrun_amisha`; the bit is dropped.
  - `ready_amisha`=1 and `start_amisha`=0: clear `q_valid_amisha`, go to IDLE.
  - `ready_amisha`=1 and `start_amisha`=1: clear `q_valid_amisha`, begin a new frame (same actions as the IDLE start), go to SHIFT.
  - `start_amisha` without ready is ignored.
- `busy_amisha` = (state == SHIFT).
- `overrun_amisha` clears only on reset or on an accepted start.
- `q_amisha` keeps its last value after the handshake; it changes only on frame completion or reset.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Start accepted at edge k: `busy_amisha`=1 from cycle k+1, and the first bit may be valid in cycle k+1.
- Nth valid bit sampled at edge m: from cycle m+1, `q_valid_amisha`=1, `q_amisha`=word, `busy_amisha`=0.
- Minimum frame duration: 1 start cycle plus N bit cycles; the word is visible 1 cycle after the last bit.
- Handshake: the word transfers at the edge where `q_valid_amisha`=1 and `ready_amisha`=1; `q_valid_amisha` drops the following cycle.
- Ready held high continuously gives a 1-cycle HOLD.
- Back-to-back frames (ready+start in HOLD): the next frame's first bit is accepted the cycle after the handshake edge.

## Test plan
- Reset, then start with dir=0, then bits 1,0,1,1,0,0,1,0 on consecutive cycles, ready=1 -> `q_amisha`=8'hB2 and `q_valid_amisha`=1 for exactly one cycle, 1 cycle after the 8th bit; `busy_amisha` high for 8 cycles.
- Start with dir=1, same bit sequence with a 2-cycle valid gap after bit 3, ready=0 -> `q_amisha`=8'h4D; `q_valid_amisha` held until ready is raised, then falls 1 cycle later with `q_amisha` still 8'h4D.
- Word pending (ready=0), sin_valid pulse -> `overrun_amisha`=1 and `q_amisha` unchanged. Then ready+start together -> overrun clears, `busy_amisha`=1 the next cycle, and a following 8-bit frame 8'hFF completes correctly.
- dir=0 frame: 4 bits (1,1,1,1) sent, then start re-asserted, then 8'h01 sent MSB-first -> `q_amisha`=8'h01; the partial bits are discarded.
- Reset asserted after 5 bits of a frame, then released -> all outputs 0 and state IDLE; sin_valid without start produces no capture; a new start with 8'h3C completes with `q_amisha`=8'h3C.
- N_amisha=2 instance, dir=0, bits 1,0 -> `q_amisha`=2'b10 one cycle after the second bit.

Source files
------------

// File: rtl/sipo_rx_amisha.sv
// Serial-in parallel-out frame receiver: word appears 1 cycle after its Nth valid bit.
// Word is held until ready; valid bits arriving while a word is pending are dropped and flagged.
module sipo_rx_amisha #(
  parameter int N_amisha = 8
) (
  input  logic                clk_amisha,
  input  logic                reset_amisha,
  input  logic                start_amisha,
  input  logic                dir_amisha,
  input  logic                sin_amisha,
  input  logic                sin_valid_amisha,
  input  logic                ready_amisha,
  output logic [N_amisha-1:0] q_amisha,
  output logic                q_valid_amisha,
  output logic                busy_amisha,
  output logic                overrun_amisha
);

  localparam int CNT_W = $clog2(N_amisha);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_amisha - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_amisha-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic [N_amisha-1:0] q_q, q_d;
  logic                q_valid_q, q_valid_d;
  logic                overrun_q, overrun_d;
  logic [N_amisha-1:0] sr_shift;

  // dir 0 shifts toward MSB (MSB-first), dir 1 shifts toward LSB (LSB-first)
  assign sr_shift = dir_q ? {sin_amisha, sr_q[N_amisha-1:1]}
                          : {sr_q[N_amisha-2:0], sin_amisha};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (start_amisha) begin
          sr_d      = '0;
          cnt_d     = '0;
          dir_d     = dir_amisha;
          overrun_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (start_amisha) begin
          sr_d  = '0;
          cnt_d = '0;
          dir_d = dir_amisha;
          overrun_d = 1'b0;
        end else if (sin_valid_amisha) begin
          sr_d = sr_shift;
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            q_d       = sr_shift;
            q_valid_d = 1'b1;
            state_d   = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (sin_valid_amisha) overrun_d = 1'b1;
        if (ready_amisha) begin
          q_valid_d = 1'b0;
          state_d   = IDLE;
          // Accepted start clears overrun even if a dropped bit arrives this cycle
          if (start_amisha) begin
            sr_d      = '0;
            cnt_d     = '0;
            dir_d     = dir_amisha;
            overrun_d = 1'b0;
            state_d   = SHIFT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign q_amisha       = q_q;
  assign q_valid_amisha = q_valid_q;
  assign busy_amisha    = (state_q == SHIFT);
  assign overrun_amisha = overrun_q;

endmodule

// File: tb/tb_sipo_rx_amisha.sv
// Directed bench for sipo_rx_amisha: 8-bit and 2-bit instances, expected words queued at drive time.
module tb_sipo_rx_amisha;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, dir, sin, sin_valid, ready;
  logic [7:0] q;
  logic       q_valid, busy, overrun;

  logic       start2, dir2, sin2, sin_valid2, ready2;
  logic [1:0] q2;
  logic       q_valid2, busy2, overrun2;

  int total = 0;
  int bad   = 0;
  logic [7:0] sq[$];
  int bcnt;

  sipo_rx_amisha #(.N_amisha(8)) dut (
    .clk_amisha(clk), .reset_amisha(reset), .start_amisha(start), .dir_amisha(dir),
    .sin_amisha(sin), .sin_valid_amisha(sin_valid), .ready_amisha(ready),
    .q_amisha(q), .q_valid_amisha(q_valid), .busy_amisha(busy), .overrun_amisha(overrun)
  );

  sipo_rx_amisha #(.N_amisha(2)) dut2 (
    .clk_amisha(clk), .reset_amisha(reset), .start_amisha(start2), .dir_amisha(dir2),
    .sin_amisha(sin2), .sin_valid_amisha(sin_valid2), .ready_amisha(ready2),
    .q_amisha(q2), .q_valid_amisha(q_valid2), .busy_amisha(busy2), .overrun_amisha(overrun2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic d);
    @(negedge clk);
    start = 1'b1; dir = d; sin_valid = 1'b0;
  endtask

  // Sends stream[7], stream[6], ... in time order; optional gap after bit gap_after.
  task automatic send_stream(input logic [7:0] stream, input int nbits,
                             input int gap_after, input int gap_len, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      start = 1'b0; sin = stream[7-i]; sin_valid = 1'b1;
      if (i + 1 == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          sin_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_word(input string tag);
    int n;
    logic [7:0] exp;
    @(negedge clk);
    start = 1'b0; sin_valid = 1'b0;
    n = 0;
    while (q_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 0);
    chk({tag, "_busy_low"}, busy, 1'b0);
    if (sq.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      exp = sq.pop_front();
      chk({tag, "_word"}, q, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; sin = 1'b0; sin_valid = 1'b0; ready = 1'b0;
    start2 = 1'b0; dir2 = 1'b0; sin2 = 1'b0; sin_valid2 = 1'b0; ready2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 8'h00);
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b0;

    // Frame 1: MSB-first B2, ready held high
    ready = 1'b1;
    do_start(1'b0);
    sq.push_back(8'hB2);
    send_stream(8'b1011_0010, 8, 0, 0, bcnt);
    chk("f1_busy_cycles", bcnt, 8);
    wait_word("f1");
    @(negedge clk);
    chk("f1_q_valid_one_cycle", q_valid, 1'b0);
    chk("f1_q_kept", q, 8'hB2);

    // Frame 2: LSB-first, gap after bit 3, ready low
    ready = 1'b0;
    do_start(1'b1);
    sq.push_back(8'h4D);
    send_stream(8'b1011_0010, 8, 3, 2, bcnt);
    wait_word("f2");
    repeat (3) begin
      @(negedge clk);
      chk("f2_hold_valid", q_valid, 1'b1);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("f2_valid_drop", q_valid, 1'b0);
    chk("f2_q_kept", q, 8'h4D);
    ready = 1'b0;

    // Overrun while pending, start without ready ignored, then ready+start
    do_start(1'b0);
    sq.push_back(8'hA5);
    send_stream(8'hA5, 8, 0, 0, bcnt);
    wait_word("f3");
    sin = 1'b0; sin_valid = 1'b1;
    @(negedge clk);
    sin_valid = 1'b0;
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_q_kept", q, 8'hA5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ovr_start_no_ready_busy", busy, 1'b0);
    chk("ovr_start_no_ready_valid", q_valid, 1'b1);
    chk("ovr_sticky", overrun, 1'b1);
    start = 1'b1; ready = 1'b1; dir = 1'b0;
    sq.push_back(8'hFF);
    send_stream(8'hFF, 8, 0, 0, bcnt);
    chk("b2b_busy_cycles", bcnt, 8);
    chk("b2b_overrun_cleared", overrun, 1'b0);
    wait_word("f4");

    // Abort after 4 bits, restart with dropped same-cycle bit, then 01
    do_start(1'b0);
    send_stream(8'hF0, 4, 0, 0, bcnt);
    @(negedge clk);
    start = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    sq.push_back(8'h01);
    send_stream(8'h01, 8, 0, 0, bcnt);
    wait_word("f5_abort");

    // Reset mid-frame
    do_start(1'b0);
    send_stream(8'hFF, 5, 0, 0, bcnt);
    @(negedge clk);
    reset = 1'b1; sin_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_q", q, 8'h00);
    chk("mid_rst_q_valid", q_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_overrun", overrun, 1'b0);
    sin = 1'b1; sin_valid = 1'b1;
    repeat (10) @(negedge clk);
    sin_valid = 1'b0;
    chk("idle_ignore_valid", q_valid, 1'b0);
    chk("idle_ignore_busy", busy, 1'b0);
    chk("idle_ignore_q", q, 8'h00);
    do_start(1'b0);
    sq.push_back(8'h3C);
    send_stream(8'h3C, 8, 0, 0, bcnt);
    wait_word("f6");

    // N=2 instance
    @(negedge clk);
    start2 = 1'b1; dir2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0; sin2 = 1'b1; sin_valid2 = 1'b1;
    @(negedge clk);
    sin2 = 1'b0;
    chk("n2_not_yet", q_valid2, 1'b0);
    @(negedge clk);
    sin_valid2 = 1'b0;
    chk("n2_valid", q_valid2, 1'b1);
    chk("n2_word", q2, 2'b10);
    chk("n2_busy", busy2, 1'b0);

    chk("queue_drained", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
